// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core load/store path, the host port and the data memory.
// The arbiter uses the slave modport; the requesters/memory side uses master.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdat;
  logic          core_gnt;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdat;

  logic          host_req;
  logic          host_we;
  logic          host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdat;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdat;

  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdat;
  logic [DW-1:0] mem_rdat;

  modport slave (
    input  core_req, core_we, core_addr, core_wdat,
    input  host_req, host_we, host_lock, host_addr, host_wdat,
    input  mem_rdat,
    output core_gnt, core_stall, core_rvalid, core_rdat,
    output host_gnt, host_rvalid, host_rdat,
    output mem_wen, mem_addr, mem_wdat
  );

  modport master (
    output core_req, core_we, core_addr, core_wdat,
    output host_req, host_we, host_lock, host_addr, host_wdat,
    output mem_rdat,
    input  core_gnt, core_stall, core_rvalid, core_rdat,
    input  host_gnt, host_rvalid, host_rdat,
    input  mem_wen, mem_addr, mem_wdat
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: core load/store path vs host port.
// One access per cycle, combinational grant, registered read data back to the winner.
// Optional host burst lock is built only when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CORE, HOST} owner_t;

  owner_t        owner_q, owner_d;
  owner_t        last_q, last_d;
  logic          core_gnt_c, host_gnt_c;
  logic          lock_hold;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdat_c;
  logic          wen_c;

  logic          core_rvalid_q, host_rvalid_q;
  logic [DW-1:0] core_rdat_q, host_rdat_q;

`ifdef DMEM_ARB_LOCK_EN
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  // Host keeps the memory while it holds the lock and has not used up its burst allowance
  assign lock_hold = bus.host_lock && (owner_q == HOST) && (lock_cnt_q < CW'(LOCK_MAX));

  // Count consecutive locked host grants, saturating at the allowance
  always_comb begin
    lock_cnt_d = '0;
    if (host_gnt_c && bus.host_lock) begin
      lock_cnt_d = (lock_cnt_q == CW'(LOCK_MAX)) ? lock_cnt_q : lock_cnt_q + CW'(1);
    end
  end

  // Burst counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_cnt_q <= '0;
    else        lock_cnt_q <= lock_cnt_d;
  end
`else
  logic unused_cfg;

  assign lock_hold  = 1'b0;
  assign unused_cfg = bus.host_lock ^ (LOCK_MAX == 0) ^ (owner_q == IDLE);
`endif

  // Owner / last-owner state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= IDLE;
      last_q  <= HOST;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Arbitration, next owner and memory mux; everything quiet while reset is held
  always_comb begin
    owner_d    = IDLE;
    last_d     = last_q;
    core_gnt_c = 1'b0;
    host_gnt_c = 1'b0;
    addr_c     = '0;
    wdat_c     = '0;
    wen_c      = 1'b0;
    if (rst_n) begin
      if (bus.core_req && bus.host_req) begin
        if (lock_hold)            host_gnt_c = 1'b1;
        else if (last_q == HOST)  core_gnt_c = 1'b1;
        else                      host_gnt_c = 1'b1;
      end else begin
        core_gnt_c = bus.core_req;
        host_gnt_c = bus.host_req;
      end
      if (core_gnt_c) begin
        addr_c  = bus.core_addr;
        wdat_c  = bus.core_wdat;
        wen_c   = bus.core_we;
        owner_d = CORE;
        last_d  = CORE;
      end else if (host_gnt_c) begin
        addr_c  = bus.host_addr;
        wdat_c  = bus.host_wdat;
        wen_c   = bus.host_we;
        owner_d = HOST;
        last_d  = HOST;
      end
    end
  end

  // Capture read data for the winner of a granted read; rdat holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      core_rdat_q   <= '0;
      host_rdat_q   <= '0;
    end else begin
      core_rvalid_q <= core_gnt_c && !bus.core_we;
      host_rvalid_q <= host_gnt_c && !bus.host_we;
      if (core_gnt_c && !bus.core_we) core_rdat_q <= bus.mem_rdat;
      if (host_gnt_c && !bus.host_we) host_rdat_q <= bus.mem_rdat;
    end
  end

  assign bus.core_gnt    = core_gnt_c;
  assign bus.host_gnt    = host_gnt_c;
  assign bus.core_stall  = rst_n && bus.core_req && !core_gnt_c;
  assign bus.mem_wen     = wen_c;
  assign bus.mem_addr    = addr_c;
  assign bus.mem_wdat    = wdat_c;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.core_rdat   = core_rdat_q;
  assign bus.host_rdat   = host_rdat_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset/lock sequences, random traffic
// against a reference model of the sharing rules and a shadow copy of memory.
module tb_dmem_arbiter;

  localparam int unsigned AW       = 8;
  localparam int unsigned DW       = 8;
  localparam int unsigned LOCK_MAX = 4;
`ifdef DMEM_ARB_LOCK_EN
  localparam bit TBL_LOCK = 1'b0;
`else
  localparam bit TBL_LOCK = 1'b1;
`endif

  typedef struct {
    bit       creq, cwe;
    bit [7:0] caddr, cwdat;
    bit       hreq, hwe, hlock;
    bit [7:0] haddr, hwdat;
    bit       e_cgnt, e_hgnt, e_stall, e_wen;
    bit       e_crv;
    bit [7:0] e_crd;
    bit       e_hrv;
    bit [7:0] e_hrd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory: combinational read, write on the clock edge
  logic [7:0] mem [256];
  assign bus.mem_rdat = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdat;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] ref_mem [256];
  int         m_last;   // 0 core, 1 host: who went most recently
  int         m_prev;   // previous cycle's winner, -1 when idle
  int         m_run;    // consecutive locked host grants
  bit         e_crv, e_hrv;
  logic [7:0] e_crd, e_hrd;
  bit         seen_hgnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_prev = -1; m_run = 0;
    e_crv = 0; e_hrv = 0; e_crd = '0; e_hrd = '0;
  endtask

  task automatic clear_inputs();
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = '0; bus.core_wdat = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_lock = 0; bus.host_addr = '0; bus.host_wdat = '0;
  endtask

  // Assert reset with live requests and check everything is quiet
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 0;
    bus.core_req = 1; bus.core_we = 1; bus.core_addr = 8'h55; bus.core_wdat = 8'hEE;
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h66; bus.host_wdat = 8'hDD;
    #1;
    chk("rst core_gnt", bus.core_gnt, 0);
    chk("rst host_gnt", bus.host_gnt, 0);
    chk("rst mem_wen", bus.mem_wen, 0);
    chk("rst core_stall", bus.core_stall, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst mem_wdat", bus.mem_wdat, 0);
    chk("rst core_rvalid", bus.core_rvalid, 0);
    chk("rst host_rvalid", bus.host_rvalid, 0);
    chk("rst core_rdat", bus.core_rdat, 0);
    chk("rst host_rdat", bus.host_rdat, 0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    model_reset();
  endtask

  // One clock of traffic: model-checked, and optionally against table expectations
  task automatic do_cycle(input vec_t v, input bit has_exp);
    int w;
    @(negedge clk);
    bus.core_req = v.creq; bus.core_we = v.cwe; bus.core_addr = v.caddr; bus.core_wdat = v.cwdat;
    bus.host_req = v.hreq; bus.host_we = v.hwe; bus.host_lock = v.hlock;
    bus.host_addr = v.haddr; bus.host_wdat = v.hwdat;
    #1;
    if (v.creq && v.hreq) begin
      w = (m_last == 1) ? 0 : 1;
`ifdef DMEM_ARB_LOCK_EN
      if (v.hlock && m_prev == 1 && m_run < LOCK_MAX) w = 1;
`endif
    end else if (v.creq) w = 0;
    else if (v.hreq) w = 1;
    else w = -1;

    seen_hgnt = bus.host_gnt;
    chk("core_gnt", bus.core_gnt, (w == 0));
    chk("host_gnt", bus.host_gnt, (w == 1));
    chk("core_stall", bus.core_stall, (v.creq && w != 0));
    chk("mem_wen", bus.mem_wen, (w == 0 && v.cwe) || (w == 1 && v.hwe));
    if (w == 0) begin
      chk("mem_addr", bus.mem_addr, v.caddr);
      if (v.cwe) chk("mem_wdat", bus.mem_wdat, v.cwdat);
    end else if (w == 1) begin
      chk("mem_addr", bus.mem_addr, v.haddr);
      if (v.hwe) chk("mem_wdat", bus.mem_wdat, v.hwdat);
    end
    if (has_exp) begin
      chk("tbl core_gnt", bus.core_gnt, v.e_cgnt);
      chk("tbl host_gnt", bus.host_gnt, v.e_hgnt);
      chk("tbl core_stall", bus.core_stall, v.e_stall);
      chk("tbl mem_wen", bus.mem_wen, v.e_wen);
    end

    e_crv = 0; e_hrv = 0;
    if (w == 0) begin
      if (v.cwe) ref_mem[v.caddr] = v.cwdat;
      else begin e_crv = 1; e_crd = ref_mem[v.caddr]; end
    end else if (w == 1) begin
      if (v.hwe) ref_mem[v.haddr] = v.hwdat;
      else begin e_hrv = 1; e_hrd = ref_mem[v.haddr]; end
    end
    if (w >= 0) m_last = w;
    m_prev = w;
    m_run  = (w == 1 && v.hlock) ? ((m_run < LOCK_MAX) ? m_run + 1 : m_run) : 0;

    @(posedge clk);
    #1;
    chk("core_rvalid", bus.core_rvalid, e_crv);
    chk("host_rvalid", bus.host_rvalid, e_hrv);
    chk("core_rdat", bus.core_rdat, e_crd);
    chk("host_rdat", bus.host_rdat, e_hrd);
    if (has_exp) begin
      chk("tbl core_rvalid", bus.core_rvalid, v.e_crv);
      chk("tbl core_rdat", bus.core_rdat, v.e_crd);
      chk("tbl host_rvalid", bus.host_rvalid, v.e_hrv);
      chk("tbl host_rdat", bus.host_rdat, v.e_hrd);
    end
  endtask

  function automatic vec_t mk(bit creq, bit cwe, bit [7:0] caddr, bit [7:0] cwdat,
                              bit hreq, bit hwe, bit hlock, bit [7:0] haddr, bit [7:0] hwdat,
                              bit cg, bit hg, bit st, bit wen,
                              bit crv, bit [7:0] crd, bit hrv, bit [7:0] hrd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdat = cwdat;
    v.hreq = hreq; v.hwe = hwe; v.hlock = hlock; v.haddr = haddr; v.hwdat = hwdat;
    v.e_cgnt = cg; v.e_hgnt = hg; v.e_stall = st; v.e_wen = wen;
    v.e_crv = crv; v.e_crd = crd; v.e_hrv = hrv; v.e_hrd = hrd;
    return v;
  endfunction

  vec_t tbl [10];
  vec_t v;

  initial begin
    // Directed table, applied right after a reset (last owner = host, rdats = 0)
    tbl[0] = mk(0,0,8'h00,8'h00, 1,1,0,8'h10,8'hA5, 0,1,0,1, 0,8'h00, 0,8'h00);
    tbl[1] = mk(1,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,0, 1,8'hA5, 0,8'h00);
    tbl[2] = mk(0,0,8'h00,8'h00, 1,1,0,8'h20,8'h11, 0,1,0,1, 0,8'hA5, 0,8'h00);
    tbl[3] = mk(1,0,8'h20,8'h00, 1,1,0,8'h20,8'h3C, 1,0,0,0, 1,8'h11, 0,8'h00);
    tbl[4] = mk(1,0,8'h20,8'h00, 1,1,0,8'h20,8'h3C, 0,1,1,1, 0,8'h11, 0,8'h00);
    tbl[5] = mk(1,0,8'h20,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,0, 1,8'h3C, 0,8'h00);
    tbl[6] = mk(1,0,8'h10,8'h00, 1,0,TBL_LOCK,8'h20,8'h00, 0,1,1,0, 0,8'h3C, 1,8'h3C);
    tbl[7] = mk(1,0,8'h10,8'h00, 1,0,TBL_LOCK,8'h20,8'h00, 1,0,0,0, 1,8'hA5, 0,8'h3C);
    tbl[8] = mk(1,0,8'h10,8'h00, 1,0,TBL_LOCK,8'h20,8'h00, 0,1,1,0, 0,8'hA5, 1,8'h3C);
    tbl[9] = mk(1,0,8'h10,8'h00, 1,0,TBL_LOCK,8'h20,8'h00, 1,0,0,0, 1,8'hA5, 0,8'h3C);

    clear_inputs();
    model_reset();
    #2 rst_n = 0;
    reset_dut();

    // Fill memory through the host port so every address has a known value
    for (int a = 0; a < 256; a++) begin
      v = mk(0,0,8'h00,8'h00, 1,1,0,8'(a),8'(a) ^ 8'h5A, 0,0,0,0, 0,8'h00, 0,8'h00);
      do_cycle(v, 0);
    end

    reset_dut();
    for (int i = 0; i < 10; i++) do_cycle(tbl[i], 1);

    // Read granted, then reset asserted in the cycle its rvalid is showing
    @(negedge clk);
    bus.core_req = 1; bus.core_we = 0; bus.core_addr = 8'h10; bus.host_req = 0;
    #1;
    chk("mid core_gnt", bus.core_gnt, 1);
    @(posedge clk);
    #1;
    chk("mid core_rvalid pre", bus.core_rvalid, 1);
    chk("mid core_rdat pre", bus.core_rdat, 8'hA5);
    rst_n = 0;
    bus.core_we = 1; bus.core_addr = 8'h30; bus.core_wdat = 8'h77;
    #1;
    chk("mid core_rvalid rst", bus.core_rvalid, 0);
    chk("mid core_gnt rst", bus.core_gnt, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("mid mem_wen rst", bus.mem_wen, 0);
      chk("mid core_rvalid hold", bus.core_rvalid, 0);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("post core_rvalid", bus.core_rvalid, 0);
      chk("post host_rvalid", bus.host_rvalid, 0);
    end
    // The store attempted under reset must not have reached memory
    v = mk(1,0,8'h30,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,0, 1,8'h30 ^ 8'h5A, 0,8'h00);
    do_cycle(v, 1);

`ifdef DMEM_ARB_LOCK_EN
    // Host burst lock: one solo locked grant, then contention H,H,H,C,H
    reset_dut();
    v = mk(0,0,8'h00,8'h00, 1,0,1,8'h20,8'h00, 0,0,0,0, 0,8'h00, 0,8'h00);
    do_cycle(v, 0);
    for (int i = 0; i < 5; i++) begin
      v = mk(1,0,8'h10,8'h00, 1,0,1,8'h20,8'h00, 0,0,0,0, 0,8'h00, 0,8'h00);
      do_cycle(v, 0);
      chk("lock seq host_gnt", seen_hgnt, (i == 3) ? 1'b0 : 1'b1);
    end
`endif

    // Random traffic on a small address window to provoke same-address hazards
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      v.creq  = 1'($urandom_range(0, 1));
      v.cwe   = 1'($urandom_range(0, 1));
      v.caddr = 8'($urandom_range(0, 15));
      v.cwdat = 8'($urandom);
      v.hreq  = 1'($urandom_range(0, 1));
      v.hwe   = 1'($urandom_range(0, 1));
      v.hlock = ($urandom_range(0, 3) != 0);
      v.haddr = 8'($urandom_range(0, 15));
      v.hwdat = 8'($urandom);
      do_cycle(v, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
